// File: rtl/acc_reduce.sv
// Sums LEN consecutive R/D tokens into one result token (optional unsigned saturation); FLUSH closes a partial group.
// Latency 1 cycle from the closing token/FLUSH; valid-only stream, no backpressure, EN stalls every register.
module acc_reduce #(
    parameter int N   = 16,
    parameter int LEN = 8,
    parameter int CW  = 16,
    parameter int SAT = 0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic          R_IN,
    input  logic [N-1:0]  D_IN,
    input  logic          FLUSH,
    output logic          R_OUT,
    output logic [N-1:0]  D_OUT,
    output logic [CW-1:0] CNT
);

    localparam logic [CW-1:0] LEN_C = CW'(LEN);

    logic [N-1:0]  acc;
    logic [N:0]    sum_wide;
    logic [N-1:0]  sum_next;
    logic [CW-1:0] cnt_next;
    logic          close;

    always_comb begin
        sum_wide = {1'b0, acc} + (R_IN ? {1'b0, D_IN} : '0);
        // Once clamped, acc stays at all-ones: adding an unsigned token can only carry out again.
        if (SAT != 0 && sum_wide[N])
            sum_next = '1;
        else
            sum_next = sum_wide[N-1:0];
        cnt_next = CNT + CW'(R_IN);
        close    = (R_IN && cnt_next == LEN_C) || (FLUSH && cnt_next != '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            R_OUT <= 1'b0;
            D_OUT <= '0;
            CNT   <= '0;
            acc   <= '0;
        end else if (EN) begin
            R_OUT <= close;
            if (close) begin
                D_OUT <= sum_next;
                acc   <= '0;
                CNT   <= '0;
            end else begin
                acc   <= sum_next;
                CNT   <= cnt_next;
            end
        end
    end

endmodule

// File: tb/tb_acc_reduce.sv
// Drives one shared token stream into six differently-parameterised reducers and
// compares each against a per-instance group-sum reference model every cycle.
module tb_acc_reduce;

    localparam int NI = 6;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        r_in = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] d_in = '0;

    always #5 CLK = ~CLK;

    // instance parameters: {N, LEN, SAT}
    int m_n   [NI] = '{16, 8, 8, 16, 16, 8};
    int m_len [NI] = '{4,  2, 2, 8,  1,  3};
    int m_sat [NI] = '{0,  0, 1, 1,  0,  0};

    logic        o_r [NI];
    logic [15:0] o_d [NI];
    logic [15:0] o_c [NI];

    logic [15:0] d0, d3, d4;
    logic [7:0]  d1, d2, d5;
    logic [15:0] c0;
    logic [3:0]  c1, c2, c3;
    logic [0:0]  c4;
    logic [1:0]  c5;

    acc_reduce #(.N(16), .LEN(4), .CW(16), .SAT(0)) u0 (.CLK(CLK), .RST(rst), .EN(en), .R_IN(r_in),
        .D_IN(d_in), .FLUSH(flush), .R_OUT(o_r[0]), .D_OUT(d0), .CNT(c0));
    acc_reduce #(.N(8), .LEN(2), .CW(4), .SAT(0)) u1 (.CLK(CLK), .RST(rst), .EN(en), .R_IN(r_in),
        .D_IN(d_in[7:0]), .FLUSH(flush), .R_OUT(o_r[1]), .D_OUT(d1), .CNT(c1));
    acc_reduce #(.N(8), .LEN(2), .CW(4), .SAT(1)) u2 (.CLK(CLK), .RST(rst), .EN(en), .R_IN(r_in),
        .D_IN(d_in[7:0]), .FLUSH(flush), .R_OUT(o_r[2]), .D_OUT(d2), .CNT(c2));
    acc_reduce #(.N(16), .LEN(8), .CW(4), .SAT(1)) u3 (.CLK(CLK), .RST(rst), .EN(en), .R_IN(r_in),
        .D_IN(d_in), .FLUSH(flush), .R_OUT(o_r[3]), .D_OUT(d3), .CNT(c3));
    acc_reduce #(.N(16), .LEN(1), .CW(1), .SAT(0)) u4 (.CLK(CLK), .RST(rst), .EN(en), .R_IN(r_in),
        .D_IN(d_in), .FLUSH(flush), .R_OUT(o_r[4]), .D_OUT(d4), .CNT(c4));
    acc_reduce #(.N(8), .LEN(3), .CW(2), .SAT(0)) u5 (.CLK(CLK), .RST(rst), .EN(en), .R_IN(r_in),
        .D_IN(d_in[7:0]), .FLUSH(flush), .R_OUT(o_r[5]), .D_OUT(d5), .CNT(c5));

    assign o_d[0] = d0;
    assign o_d[1] = {8'h00, d1};
    assign o_d[2] = {8'h00, d2};
    assign o_d[3] = d3;
    assign o_d[4] = d4;
    assign o_d[5] = {8'h00, d5};
    assign o_c[0] = c0;
    assign o_c[1] = {12'h000, c1};
    assign o_c[2] = {12'h000, c2};
    assign o_c[3] = {12'h000, c3};
    assign o_c[4] = {15'h0000, c4};
    assign o_c[5] = {14'h0000, c5};

    int total = 0;
    int bad = 0;

    // reference state: the tokens of the open group are kept as a plain unbounded total
    longint m_tot [NI];
    int     m_cnt [NI];
    logic   m_r   [NI];
    longint m_d   [NI];

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            longint maxv;
            bit     take, cl;
            maxv = (64'd1 << m_n[i]) - 1;
            if (rst) begin
                m_tot[i] = 0; m_cnt[i] = 0; m_r[i] = 1'b0; m_d[i] = 0;
            end else if (en) begin
                take = r_in;
                if (take) begin
                    m_tot[i] += longint'(d_in) & maxv;
                    m_cnt[i] += 1;
                end
                cl = (take && m_cnt[i] == m_len[i]) || (flush && m_cnt[i] != 0);
                m_r[i] = cl;
                if (cl) begin
                    m_d[i]   = (m_sat[i] != 0) ? ((m_tot[i] > maxv) ? maxv : m_tot[i])
                                               : (m_tot[i] % (maxv + 1));
                    m_tot[i] = 0;
                    m_cnt[i] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("r_out[%0d]", i), longint'(o_r[i]), longint'(m_r[i]));
            chk($sformatf("d_out[%0d]", i), longint'(o_d[i]), m_d[i]);
            chk($sformatf("cnt[%0d]", i), longint'(o_c[i]), longint'(m_cnt[i]));
        end
    endtask

    task automatic step(input logic r, input logic [15:0] d, input logic f, input logic e);
        r_in = r; d_in = d; flush = f; en = e;
        @(posedge CLK);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_rst(input int n);
        rst = 1'b1;
        for (int k = 0; k < n; k++) step(1'b0, 16'd0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_tot[i] = 0; m_cnt[i] = 0; m_r[i] = 1'b0; m_d[i] = 0;
        end

        // reset and idle
        do_rst(2);
        chk("rst_r0", longint'(o_r[0]), 0);
        chk("rst_d0", longint'(o_d[0]), 0);
        for (int k = 0; k < 10; k++) step(1'b0, 16'd0, 1'b0, 1'b1);

        // basic group on LEN=4
        for (int t = 1; t <= 4; t++) begin
            step(1'b1, 16'(t), 1'b0, 1'b1);
            chk($sformatf("basic_cnt_t%0d", t), longint'(o_c[0]), (t == 4) ? 0 : t);
        end
        chk("basic_pulse", longint'(o_r[0]), 1);
        chk("basic_sum", longint'(o_d[0]), 10);
        step(1'b0, 16'd0, 1'b0, 1'b1);
        chk("basic_pulse_end", longint'(o_r[0]), 0);

        // back-to-back groups with a 3-cycle stall after token 2
        do_rst(1);
        step(1'b1, 16'd1, 1'b0, 1'b1);
        step(1'b1, 16'd2, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, 16'd99, 1'b1, 1'b0);
        for (int t = 3; t <= 8; t++) begin
            step(1'b1, 16'(t), 1'b0, 1'b1);
            if (t == 4) chk("stall_sum1", longint'(o_d[0]), 10);
        end
        chk("stall_sum2", longint'(o_d[0]), 26);
        chk("stall_pulse2", longint'(o_r[0]), 1);

        // wrap vs saturate on N=8, LEN=2
        do_rst(1);
        step(1'b1, 16'd200, 1'b0, 1'b1);
        step(1'b1, 16'd100, 1'b0, 1'b1);
        chk("wrap_sum", longint'(o_d[1]), 44);
        chk("sat_sum", longint'(o_d[2]), 255);

        // flush cases on LEN=8
        do_rst(1);
        step(1'b1, 16'd5, 1'b0, 1'b1);
        step(1'b1, 16'd6, 1'b0, 1'b1);
        step(1'b1, 16'd7, 1'b0, 1'b1);
        step(1'b0, 16'd0, 1'b1, 1'b1);
        chk("flush_alone", longint'(o_d[3]), 18);
        step(1'b1, 16'd5, 1'b0, 1'b1);
        step(1'b1, 16'd6, 1'b0, 1'b1);
        step(1'b1, 16'd9, 1'b1, 1'b1);
        chk("flush_with_tok", longint'(o_d[3]), 20);
        step(1'b0, 16'd0, 1'b1, 1'b1);
        chk("flush_empty", longint'(o_r[3]), 0);
        for (int t = 1; t <= 8; t++) step(1'b1, 16'(t), (t == 8), 1'b1);
        chk("flush_on_len", longint'(o_r[3]), 1);
        chk("flush_on_len_sum", longint'(o_d[3]), 36);
        step(1'b0, 16'd0, 1'b0, 1'b1);
        chk("flush_on_len_once", longint'(o_r[3]), 0);

        // reset mid-group discards the partial sum
        do_rst(1);
        step(1'b1, 16'd7, 1'b0, 1'b1);
        step(1'b1, 16'd7, 1'b0, 1'b1);
        do_rst(1);
        chk("midrst_no_pulse", longint'(o_r[0]), 0);
        for (int t = 0; t < 4; t++) step(1'b1, 16'd1, 1'b0, 1'b1);
        chk("midrst_sum", longint'(o_d[0]), 4);

        // randomized traffic, biased toward large values to exercise overflow
        for (int k = 0; k < 3000; k++) begin
            logic [15:0] d;
            case ($urandom_range(0, 2))
                0:       d = 16'($urandom);
                1:       d = 16'hFFFF - 16'($urandom_range(0, 300));
                default: d = 16'($urandom_range(0, 20));
            endcase
            rst = ($urandom_range(0, 199) == 0);
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 9) == 0, $urandom_range(0, 7) != 0);
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
